// File: rtl/mul_booth_iter_if.sv
// Request/result bundle for the iterative radix-4 Booth multiplier.
// Carries the request handshake, operands, flush, and the result handshake.
// The slave modport is the multiplier side; the master modport is the requester/consumer side.
interface mul_booth_iter_if #(
  parameter int WIDTH = 64
);
  logic               i_valid;
  logic               o_ready;
  logic [WIDTH-1:0]   i_x;
  logic [WIDTH-1:0]   i_y;
  logic               i_x_sign;
  logic               i_y_sign;
  logic               i_flush;
  logic               o_valid;
  logic               i_ready;
  logic [2*WIDTH-1:0] o_result;

  modport slave (
    input  i_valid, i_x, i_y, i_x_sign, i_y_sign, i_flush, i_ready,
    output o_ready, o_valid, o_result
  );

  modport master (
    output i_valid, i_x, i_y, i_x_sign, i_y_sign, i_flush, i_ready,
    input  o_ready, o_valid, o_result
  );
endinterface

// File: rtl/mul_booth_iter.sv
// Iterative radix-4 Booth multiplier, signed/unsigned per operand, full 2*WIDTH-bit product.
// Latency: E/2 cycles in BUSY after acceptance (E = WIDTH+2), result visible the cycle after.
// Backpressure: one operation at a time; o_ready only in IDLE, result held in DONE until i_ready.
module mul_booth_iter #(
  parameter int WIDTH = 64
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mul_booth_iter_if.slave bus
);

  // Extended operand width, accumulator width, number of radix-4 groups.
  localparam int E  = WIDTH + 2;
  localparam int AW = 2 * E;
  localparam int NG = E / 2;
  localparam int CW = (NG > 1) ? $clog2(NG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [E-1:0]  x_q, x_d;      // extended multiplicand
  logic [E:0]    y_q, y_d;      // {y_ext, 1'b0}, shifted down two bits per group
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Operand extension: replicate the sign bit only when the operand is flagged signed.
  logic         x_ext_bit, y_ext_bit;
  logic [E-1:0] x_ext, y_ext;

  assign x_ext_bit = bus.i_x_sign & bus.i_x[WIDTH-1];
  assign y_ext_bit = bus.i_y_sign & bus.i_y[WIDTH-1];
  assign x_ext     = {{2{x_ext_bit}}, bus.i_x};
  assign y_ext     = {{2{y_ext_bit}}, bus.i_y};

  // Booth decode of the current group (always sits in the low three bits of y_q).
  logic neg, two, zero;

  // Decode group bits into zero / +-X / +-2X selection.
  always_comb begin
    neg  = 1'b0;
    two  = 1'b0;
    zero = 1'b0;
    case (y_q[2:0])
      3'b000, 3'b111: zero = 1'b1;
      3'b001, 3'b010: ;
      3'b011:         two  = 1'b1;
      3'b100: begin
        neg = 1'b1;
        two = 1'b1;
      end
      3'b101, 3'b110: neg  = 1'b1;
      default:        zero = 1'b1;
    endcase
  end

  // Partial product: sign-extended magnitude, inverted for negatives with the +1
  // supplied as a separate carry term at the same weight.
  logic [AW-1:0] x_sext, mag, sel, cin_vec, pp_add;
  logic [CW:0]   sh;

  assign x_sext  = {{(AW-E){x_q[E-1]}}, x_q};
  assign mag     = two ? (x_sext << 1) : x_sext;
  assign sel     = zero ? '0 : (neg ? ~mag : mag);
  assign cin_vec = {{(AW-1){1'b0}}, neg & ~zero};
  assign sh      = {cnt_q, 1'b0};
  assign pp_add  = (sel << sh) + (cin_vec << sh);

  // Next-state and datapath update; flush outranks acceptance and the result handshake.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!bus.i_flush && bus.i_valid) begin
          x_d     = x_ext;
          y_d     = {y_ext, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.i_flush) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_q + pp_add;
          y_d   = {2'b00, y_q[E:2]};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.i_flush || bus.i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; synchronous reset discards any in-flight operation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_q   <= '0;
      y_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // Outputs: result only exposed in DONE, zero otherwise.
  assign bus.o_ready  = (state_q == IDLE);
  assign bus.o_valid  = (state_q == DONE);
  assign bus.o_result = (state_q == DONE) ? acc_q[2*WIDTH-1:0] : '0;

  // Guard bits above the product width are needed only for the modular sum.
  logic unused_acc_hi;
  assign unused_acc_hi = ^acc_q[AW-1:2*WIDTH];

endmodule

// File: doc/mul_booth_iter.md
MUL_BOOTH_ITER -- requirements
Module: mul_booth_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 64, the operand width.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port i_valid, input, 1 bit: a request is present.
REQ-005 SHALL have port o_ready, output, 1 bit: the block can accept a request.
REQ-006 SHALL have ports i_x and i_y, input, WIDTH bits each: multiplicand and multiplier.
REQ-007 SHALL have ports i_x_sign and i_y_sign, input, 1 bit each: 1 means the operand is two's complement, 0 means unsigned.
REQ-008 SHALL have port i_flush, input, 1 bit: abort the current operation.
REQ-009 SHALL have port o_valid, output, 1 bit: the result is valid.
REQ-010 SHALL have port i_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port o_result, output, 2*WIDTH bits: the full product.

Function
REQ-012 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-013 SHALL drive o_ready=1 only in IDLE.
REQ-014 SHALL drive o_valid=1 only in DONE.
REQ-015 SHALL accept a request on an edge where i_valid & o_ready & ~i_flush; on that edge it latches the operands and sign flags, clears the accumulator and counter, and moves to BUSY.
REQ-016 SHALL extend each operand to E = WIDTH+2 bits by replicating the sign bit when the sign flag is 1, or by zero when it is 0.
REQ-017 SHALL form E/2 radix-4 groups from the multiplier as {y_ext, 1'b0}; group k uses bits [2k+2:2k], for k = 0..E/2-1 (33 groups when WIDTH=64).
REQ-018 SHALL encode each group as follows, where X is the extended multiplicand:
- 000 and 111 select 0.
- 001 and 010 select +X.
- 011 selects +2X.
- 100 selects -2X.
- 101 and 110 select -X.
REQ-019 SHALL form a negative selection as the bitwise inverse of the magnitude plus a carry-in of 1.
REQ-020 SHALL process exactly one group per BUSY cycle, from k=0 upward.
REQ-021 SHALL sign-extend each selected partial product, shift it left by 2k, and add it into a 2*E-bit accumulator; all additions are modulo 2^(2*E).
REQ-022 SHALL leave BUSY for DONE on the edge that processes group E/2-1; o_valid therefore first rises in the cycle after the 33rd edge following the accepting edge.
REQ-023 SHALL drive o_result = accumulator[2*WIDTH-1:0], held stable throughout DONE.
REQ-024 SHALL produce a result equal to the exact mathematical product of the operands, interpreted per their sign flags, taken modulo 2^(2*WIDTH).
REQ-025 SHALL return from DONE to IDLE on an edge where o_valid & i_ready, and SHALL hold DONE and o_result while i_ready=0.
REQ-026 SHALL, when i_flush=1 in BUSY or DONE, go to IDLE on the next edge with no result delivered.
REQ-027 SHALL give i_flush priority over acceptance in IDLE and over the handshake in DONE.
REQ-028 SHALL ignore i_valid and the operand inputs outside IDLE; latched operands are not altered by input changes during BUSY.
REQ-029 SHALL drive o_result = 0 in IDLE and BUSY.

Reset
REQ-030 SHALL, with i_rst=1 on an edge, set state=IDLE, counter=0 and accumulator=0, so that o_ready=1, o_valid=0 and o_result=0 on the following cycle.
REQ-031 SHALL give i_rst priority over every other input, including mid-BUSY and in DONE; an in-flight operation is discarded.

Verification
REQ-032 SHALL cover: unsigned x=3, y=5 -> o_valid rises 33 edges after acceptance, o_result=15.
REQ-033 SHALL cover: signed x=y=0xFFFF_FFFF_FFFF_FFFF (-1 x -1) -> o_result=1.
REQ-034 SHALL cover: x signed 0xFFFF_FFFF_FFFF_FFFF, y unsigned 0xFFFF_FFFF_FFFF_FFFF -> o_result=0xFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001.
REQ-035 SHALL cover: unsigned x=y=0xFFFF_FFFF_FFFF_FFFF -> o_result=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001; and signed x=y=0x8000_0000_0000_0000 -> o_result=0x4000_0000_0000_0000_0000_0000_0000_0000.
REQ-036 SHALL cover: i_ready held 0 for 5 cycles in DONE -> o_valid and o_result stable; after i_ready=1, o_ready=1 on the next cycle, and a back-to-back request is accepted.
REQ-037 SHALL cover: i_flush (and separately i_rst) asserted at BUSY cycle 10 -> IDLE next cycle, o_valid never asserted; a following request 7x6 unsigned -> o_result=42.
